// File: rtl/nios_cpu_div_cell_if.sv
// Divider request/result bundle between the CPU E/M stages and nios_cpu_div_cell.
interface nios_cpu_div_cell_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] E_src1;
    logic [WIDTH-1:0] E_src2;
    logic             E_div_start;
    logic             E_div_signed;
    logic             M_flush;
    logic             M_div_busy;
    logic             M_div_done;
    logic [WIDTH-1:0] M_div_quot;
    logic [WIDTH-1:0] M_div_rem;
    logic             M_div_by_zero;

    modport master (
        output E_src1, E_src2, E_div_start, E_div_signed, M_flush,
        input  M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
    );

    modport slave (
        input  E_src1, E_src2, E_div_start, E_div_signed, M_flush,
        output M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
    );
endinterface

// File: rtl/nios_cpu_div_cell.sv
// Multi-cycle radix-2 restoring divider (div/divu) with start/done handshake and flush.
// Optional macro DIV_EARLY_OUT_EN: finish in PREP when |divisor| > |dividend|.
module nios_cpu_div_cell #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                reset,
    nios_cpu_div_cell_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d, zero_q, zero_d, byz_q, byz_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH+1:0] trial;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign mag1  = (sgn_q && src1_q[WIDTH-1]) ? -src1_q : src1_q;
    assign mag2  = (sgn_q && src2_q[WIDTH-1]) ? -src2_q : src2_q;
    // Shifted partial remainder needs WIDTH+1 bits; one extra bit carries the sign.
    assign trial = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};

    always_comb begin
        state_d = state;
        src1_d  = src1_q;
        src2_d  = src2_q;
        sgn_d   = sgn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        byz_d   = byz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = (state == S_PREP) || (state == S_CALC) || (state == S_FIXUP);
        done_d  = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (!bus.M_flush && bus.E_div_start) begin
                    src1_d  = bus.E_src1;
                    src2_d  = bus.E_src2;
                    sgn_d   = bus.E_div_signed;
                    byz_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                dvd_d  = mag1;
                dvs_d  = mag2;
                rem_d  = '0;
                cnt_d  = '0;
                zero_d = (mag2 == '0);
                if (mag2 == '0) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (mag2 > mag1) begin
                        dvd_d   = '0;
                        rem_d   = mag1;
                        state_d = S_FIXUP;
                    end
`endif
                end
                if (bus.M_flush) state_d = S_IDLE;
            end
            S_CALC: begin
                rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIXUP;
                if (bus.M_flush) state_d = S_IDLE;
            end
            S_FIXUP: begin
                if (bus.M_flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Truncating division: remainder takes the dividend's sign.
                    if (zero_q) begin
                        quot_d = '1;
                        remo_d = src1_q;
                        byz_d  = 1'b1;
                    end else begin
                        quot_d = (sgn_q && (src1_q[WIDTH-1] ^ src2_q[WIDTH-1])) ? -dvd_q : dvd_q;
                        remo_d = (sgn_q && src1_q[WIDTH-1]) ? -rem_q : rem_q;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            src1_q <= '0;
            src2_q <= '0;
            sgn_q  <= 1'b0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            byz_q  <= 1'b0;
            quot_q <= '0;
            remo_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            sgn_q  <= sgn_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            byz_q  <= byz_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.M_div_busy    = busy_q;
    assign bus.M_div_done    = done_q;
    assign bus.M_div_quot    = quot_q;
    assign bus.M_div_rem     = remo_q;
    assign bus.M_div_by_zero = byz_q;
endmodule
